// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter fed by a baud square wave.
// A small byte FIFO absorbs bursts from upstream; frames are sent
// back-to-back, LSB first, one bit per rising edge of the baud wave.
// Build option: define UART_TX_PARITY_EN to append an even-parity bit
// after bit 7 (8E1, 11-bit frames); left undefined the block sends 8N1.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clki,
  input  logic          rst,
  input  logic          baud,
  input  logic [7:0]    wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic          tx,
  output logic          busy,
  output logic [AW:0]   level
);

  // Frame sequencer states; the parity state only exists in the 8E1 build.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_e;

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  // Baud edge detection
  logic baud_q;
  logic tick;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   level_q;
  logic [AW:0]   level_d;
  logic          push;
  logic          pop;
  logic          notEmpty;
  logic [7:0]    headByte;

  // Frame sequencer
  state_e        state_q;
  state_e        state_d;
  logic [7:0]    shreg_q;
  logic [7:0]    shreg_d;
  logic [2:0]    bitcnt_q;
  logic [2:0]    bitcnt_d;
  logic          tx_q;
  logic          tx_d;
  logic          busy_q;
`ifdef UART_TX_PARITY_EN
  logic          parity_q;
  logic          parity_d;
`endif

  assign tick     = baud & ~baud_q;
  assign notEmpty = (level_q != '0);
  assign wr_ready = (level_q != FULL_LEVEL);
  assign push     = wr_valid & wr_ready;
  assign headByte = mem_q[rptr_q];

  assign tx    = tx_q;
  assign busy  = busy_q;
  assign level = level_q;

  // Remember the previous baud level; starting high means a baud wave that
  // is already high when reset lifts is not mistaken for a rising edge.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      baud_q <= 1'b1;
    end else begin
      baud_q <= baud;
    end
  end

  // Byte storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clki) begin
    if (push) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  // Fill level follows pushes and pops; both in one cycle cancel out.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      level_q <= level_d;
    end
  end

  // Next-state logic: nothing moves except on a baud tick, so a stalled
  // baud wave freezes the line. The FIFO is only popped from IDLE or STOP,
  // using the registered level, so a byte written on the same tick waits
  // for the following one.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    tx_d     = tx_q;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (notEmpty) begin
            pop      = 1'b1;
            shreg_d  = headByte;
`ifdef UART_TX_PARITY_EN
            parity_d = ^headByte;
`endif
            tx_d     = 1'b0;
            state_d  = START;
          end
        end
        START: begin
          tx_d     = shreg_q[0];
          bitcnt_d = '0;
          state_d  = DATA;
        end
        DATA: begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bitcnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            tx_d     = shreg_q[1];
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
`endif
        STOP: begin
          if (notEmpty) begin
            pop      = 1'b1;
            shreg_d  = headByte;
`ifdef UART_TX_PARITY_EN
            parity_d = ^headByte;
`endif
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Sequencer registers; reset forces the line back to idle-high at once.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      tx_q     <= tx_d;
      busy_q   <= (state_d != IDLE);
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
